cam_frame_writer: RTL and testbench



---
 rtl/cam_frame_writer.sv | 155 +++++++++++++++
 tb/tb_cam_frame_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: packs OV7670 RGB444 byte pairs into pixels and writes them to the frame buffer (CAM_TEST_PATTERN_EN: colour bars)
module cam_frame_writer #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cam_pclk,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_px_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic [6:0]    line_count
);
    localparam logic [AW-1:0] LAST  = AW'(IMG_W * IMG_H - 1);
    localparam logic [6:0]    LINES = 7'(IMG_H);

    typedef enum logic [1:0] {WAIT_FRAME, BYTE_HI, BYTE_LO} state_t;

    state_t        state_q, state_d;
    logic          pclk_s1_q, pclk_s2_q, pclk_s3_q;
    logic          vs_s1_q, vs_s2_q, vs_last_q;
    logic          hr_s1_q, hr_s2_q, hr_last_q;
    logic [7:0]    px_s1_q, px_s2_q;
    logic [3:0]    hi_q, hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d, px;
    logic          wr_q, wr_d, done_q, done_d, full_q, full_d;
    logic [6:0]    lines_q, lines_d;
    logic          pclk_rise, vs_fall, vs_rise, hr_fall, take;

    // Camera edges are judged against the level seen at the previous PCLK rise
    assign pclk_rise = pclk_s2_q & ~pclk_s3_q;
    assign vs_fall   = pclk_rise & vs_last_q & ~vs_s2_q;
    assign vs_rise   = pclk_rise & ~vs_last_q & vs_s2_q;
    assign hr_fall   = pclk_rise & hr_last_q & ~hr_s2_q;
    assign take      = pclk_rise & hr_s2_q;

    assign addr_in    = addr_q;
    assign data_in    = data_q;
    assign regwrite   = wr_q;
    assign frame_done = done_q;
    assign line_count = lines_q;

    // Two-flop synchronizers plus the per-PCLK history used for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            {pclk_s1_q, pclk_s2_q, pclk_s3_q} <= '0;
            {vs_s1_q, vs_s2_q, vs_last_q}     <= '0;
            {hr_s1_q, hr_s2_q, hr_last_q}     <= '0;
            px_s1_q <= '0;
            px_s2_q <= '0;
        end else begin
            {pclk_s1_q, pclk_s2_q, pclk_s3_q} <= {cam_pclk, pclk_s1_q, pclk_s2_q};
            {vs_s1_q, vs_s2_q} <= {cam_vsync, vs_s1_q};
            {hr_s1_q, hr_s2_q} <= {cam_href, hr_s1_q};
            px_s1_q <= cam_px_data;
            px_s2_q <= px_s1_q;
            vs_last_q <= pclk_rise ? vs_s2_q : vs_last_q;
            hr_last_q <= pclk_rise ? hr_s2_q : hr_last_q;
        end
    end

`ifdef CAM_TEST_PATTERN_EN
    localparam logic [8*12-1:0] BARS = {12'h000, 12'h00F, 12'hF00, 12'hF0F,
                                        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};
    localparam logic [AW-1:0]   W_L   = AW'(IMG_W);
    localparam logic [AW-1:0]   BAR_L = AW'(IMG_W / 8);
    logic [AW-1:0] col;
    logic [2:0]    bar;

    // Colour bar chosen by column; camera bytes are ignored
    always_comb begin
        col = addr_q % W_L;
        bar = 3'(col / BAR_L);
        px  = DW'(BARS[bar*12 +: 12]);
    end
`else
    // Latched red nibble joined with the green/blue byte
    always_comb begin
        px = DW'({hi_q, px_s2_q});
    end
`endif

    // Capture FSM, address/line bookkeeping and output strobes
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        done_d  = 1'b0;
        full_d  = full_q;
        lines_d = lines_q;
        if (wr_q) begin
            full_d = full_q | (addr_q == LAST);
            addr_d = (addr_q == LAST) ? addr_q : addr_q + AW'(1);
        end
        case (state_q)
            WAIT_FRAME: if (vs_fall) begin
                state_d = BYTE_HI;
                addr_d  = '0;
                lines_d = '0;
                full_d  = 1'b0;
            end
            BYTE_HI: if (take) begin
                hi_d    = px_s2_q[3:0];
                state_d = BYTE_LO;
            end
            BYTE_LO: begin
                if (take || hr_fall)
                    state_d = BYTE_HI;
                if (take && !full_q) begin
                    wr_d   = 1'b1;
                    data_d = px;
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
        if (hr_fall && state_q != WAIT_FRAME)
            lines_d = (lines_q == LINES) ? lines_q : lines_q + 7'd1;
        if (vs_rise && state_q != WAIT_FRAME) begin
            done_d  = 1'b1;
            state_d = WAIT_FRAME;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_FRAME;
            hi_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            lines_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            full_q  <= full_d;
            lines_q <= lines_d;
        end
    end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: table vectors and a write scoreboard for cam_frame_writer on a reduced 32x8 image
module tb_cam_frame_writer;
    localparam int AW = 15, DW = 12, W = 32, H = 8, NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst, cam_pclk, cam_vsync, cam_href;
    logic [7:0]    cam_px_data;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite, frame_done;
    logic [6:0]    line_count;

    always #5 clk = ~clk;

    cam_frame_writer #(.AW(AW), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_px_data(cam_px_data), .addr_in(addr_in),
        .data_in(data_in), .regwrite(regwrite), .frame_done(frame_done),
        .line_count(line_count)
    );

    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    typedef struct {logic [7:0] hi; logic [7:0] lo; logic [AW-1:0] a; logic [DW-1:0] d;} vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    vec_t tbl[4];
    int   n_checks = 0, n_fail = 0, n_wr = 0, n_done = 0, n_done_wr = 0;
    logic wr_prev = 1'b0;

    bit         m_act = 0, m_pend = 0, m_auto = 1;
    logic [3:0] m_hi = '0;
    int         m_addr = 0, m_lines = 0, m_done = 0;

    function automatic logic [DW-1:0] exp_px(input int addr, input logic [3:0] hi, input logic [7:0] lo);
`ifdef CAM_TEST_PATTERN_EN
        logic [8*DW-1:0] bars = {12'h000, 12'h00F, 12'hF00, 12'hF0F, 12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF};
        int bar = (addr % W) / (W / 8);
        return bars[bar*DW +: DW];
`else
        return {hi, lo};
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (regwrite) begin
                n_wr++;
                if (frame_done) n_done_wr++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0h, no write expected", addr_in, data_in);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", 32'(addr_in), 32'(mon_e.a));
                    check("write_data", 32'(data_in), 32'(mon_e.d));
                end
            end
            if (wr_prev) check("strobe_width", 32'(regwrite), 32'd0);
            if (frame_done) n_done++;
        end
        wr_prev = regwrite;
    end

    task automatic pclk_cycle();
        repeat (4) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (4) @(negedge clk);
        cam_pclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        wr_t w;
        cam_href = 1'b1;
        cam_px_data = b;
        if (m_act) begin
            if (!m_pend) begin
                m_hi = b[3:0];
                m_pend = 1;
            end else begin
                m_pend = 0;
                if (m_addr < NPIX) begin
                    w.a = AW'(m_addr);
                    w.d = exp_px(m_addr, m_hi, b);
                    if (m_auto) exp_q.push_back(w);
                    m_addr++;
                end
            end
        end
        pclk_cycle();
    endtask

    task automatic end_line();
        cam_href = 1'b0;
        if (m_act) begin
            m_pend = 0;
            if (m_lines < H) m_lines++;
        end
        pclk_cycle();
        pclk_cycle();
    endtask

    task automatic start_frame();
        cam_vsync = 1'b1;
        cam_href = 1'b0;
        pclk_cycle();
        pclk_cycle();
        cam_vsync = 1'b0;
        pclk_cycle();
        m_act = 1; m_pend = 0; m_addr = 0; m_lines = 0;
    endtask

    task automatic end_frame();
        cam_vsync = 1'b1;
        cam_href = 1'b0;
        if (m_act) m_done++;
        m_act = 0; m_pend = 0;
        pclk_cycle();
        pclk_cycle();
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_addr"}, 32'(addr_in), 32'd0);
        check({name, "_data"}, 32'(data_in), 32'd0);
        check({name, "_regwrite"}, 32'(regwrite), 32'd0);
        check({name, "_frame_done"}, 32'(frame_done), 32'd0);
        check({name, "_line_count"}, 32'(line_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wr0;
        logic [7:0] hb, lb;
        tbl[0] = '{hi: 8'h0A, lo: 8'hBC, a: 15'd0, d: 12'hABC};
        tbl[1] = '{hi: 8'h03, lo: 8'h45, a: 15'd1, d: 12'h345};
        tbl[2] = '{hi: 8'hF7, lo: 8'h00, a: 15'd2, d: 12'h700};
        tbl[3] = '{hi: 8'h5E, lo: 8'hFF, a: 15'd3, d: 12'hEFF};
        rst = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_px_data = '0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) send_byte(8'h12 + 8'(i));
        end_line();
        check("idle_writes", 32'(n_wr), 32'd0);
        check_idle("idle");

        start_frame();
        m_auto = 0;
        for (int i = 0; i < 4; i++) begin
            wr_t w;
            w.a = tbl[i].a;
`ifdef CAM_TEST_PATTERN_EN
            w.d = exp_px(int'(tbl[i].a), 4'h0, 8'h00);
`else
            w.d = tbl[i].d;
`endif
            exp_q.push_back(w);
            send_byte(tbl[i].hi);
            send_byte(tbl[i].lo);
        end
        m_auto = 1;
        drain("table_drain");
        check("table_writes", 32'(n_wr), 32'd4);
        check("table_addr_after", 32'(addr_in), 32'd4);
        end_line();
        check("table_line_count", 32'(line_count), 32'd1);
        end_frame();
        check("table_frame_done", 32'(n_done), 32'(m_done));

        start_frame();
        wr0 = n_wr;
        for (int l = 0; l < H + 2; l++) begin
            for (int p = 0; p < W; p++) begin
                hb = 8'(l * 16 + p);
                lb = 8'(p * 7 + l * 3);
                send_byte(hb);
                send_byte(lb);
            end
            end_line();
            check("frame_line_count", 32'(line_count), 32'(m_lines));
            if (l == H - 1) begin
                drain("frame_drain");
                check("frame_writes", 32'(n_wr - wr0), 32'(NPIX));
                check("frame_last_addr", 32'(addr_in), 32'(NPIX - 1));
            end
        end
        drain("overrun_drain");
        check("overrun_writes", 32'(n_wr - wr0), 32'(NPIX));
        check("overrun_addr", 32'(addr_in), 32'(NPIX - 1));
        end_frame();
        check("frame_done_count", 32'(n_done), 32'(m_done));
        check("frame_final_lines", 32'(line_count), 32'(H));

        start_frame();
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h04);
        end_line();
        send_byte(8'h05); send_byte(8'h67);
        send_byte(8'h08);
        end_frame();
        drain("odd_drain");
        check("abort_frame_done", 32'(n_done), 32'(m_done));
        start_frame();
        send_byte(8'h09); send_byte(8'hAB);
        drain("restart_drain");
        check("restart_addr", 32'(addr_in), 32'd1);

        send_byte(8'h0C);
        cam_vsync = 1'b1;
        send_byte(8'hDE);
        m_act = 0; m_pend = 0; m_done++;
        cam_href = 1'b0;
        pclk_cycle();
        drain("coincide_drain");
        check("coincide_done_with_write", 32'(n_done_wr), 32'd1);
        check("coincide_frame_done", 32'(n_done), 32'(m_done));

        start_frame();
        send_byte(8'h0F);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("midreset");
        rst = 1'b0;
        m_act = 0; m_pend = 0;
        wr0 = n_wr;
        send_byte(8'h11); send_byte(8'h22);
        end_line();
        check("midreset_no_write", 32'(n_wr - wr0), 32'd0);
        start_frame();
        send_byte(8'h03); send_byte(8'h33);
        drain("resume_drain");
        check("resume_addr", 32'(addr_in), 32'd1);
        end_line();
        end_frame();
        check("final_frame_done", 32'(n_done), 32'(m_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
